clk_rst_seq: RTL and testbench
==============================

# clk_rst_seq

Reset sequencer paired with the `ip_clk_wiz` clock generator. It drives the generator's reset, waits for its `locked` output to assert and stay stable, then releases the downstream resets in a fixed stage order. It also detects loss of lock and re-runs the whole sequence. The block sits between the clock wizard and every reset-consuming module, clocked from the free-running `sys_clk`.

## Interface
- `NUM_STAGES`, 3: number of staged downstream resets, 1..8.
- `RST_CYCLES`, 16: cycles `mmcm_rst` is held high per attempt, ≥1.
- `LOCK_TIMEOUT`, 100000: cycles allowed in WAIT_LOCK before retrying, ≥1.
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release, ≥1.
- `STAGE_GAP`, 16: cycles between successive stage releases, ≥1.
- `sys_clk` in 1: free-running system clock; the only clock in the block.
- `sys_rst_n` in 1: asynchronous assert, active-low reset. Deassertion is already synchronous to `sys_clk` upstream.
- `locked_in` in 1: `locked` output of the clock wizard. Asynchronous to `sys_clk`.
- `mmcm_rst` out 1: active-high reset to the clock wizard.
- `rst_n_out` out NUM_STAGES: active-low staged resets; bit 0 releases first.
- `ready` out 1: high while all stages are released and lock is held.
- `lock_lost` out 1: one-cycle pulse when lock drops during STABLE, RELEASE or RUN.
- `retry_cnt` out 8: saturating count of timeouts plus lock losses.

## Operation
- `locked_in` passes through a 2-flop synchronizer to give `lock_s`. Reset value of both flops is 0.
- FSM states: RESET_MMCM, WAIT_LOCK, STABLE, RELEASE, RUN. A single cycle counter `cnt` is cleared on every state change.
- **RESET_MMCM**
  - `mmcm_rst`=1, `rst_n_out`=0.
  - After RST_CYCLES cycles the FSM moves to WAIT_LOCK.
- **WAIT_LOCK**
  - `mmcm_rst`=0.
  - If `lock_s`=1, move to STABLE.
  - Otherwise, when `cnt` reaches LOCK_TIMEOUT−1, move to RESET_MMCM and increment `retry_cnt`.
- **STABLE**
  - If `lock_s`=0, pulse `lock_lost`, increment `retry_cnt`, and move to WAIT_LOCK. The timeout restarts.
  - After STABLE_CYCLES consecutive high cycles, move to RELEASE.
- **RELEASE**
  - `rst_n_out[k]` goes to 1 at `cnt`==k·STAGE_GAP.
  - After the last stage is released, move to RUN.
- **RUN**
  - `ready`=1.
- **Lock loss in RELEASE or RUN**
  - On the first cycle where `lock_s`=0: all `rst_n_out` go to 0 and `ready` goes to 0 on the next edge.
  - `lock_lost` pulses, `retry_cnt` increments, and the FSM goes to RESET_MMCM.
- `retry_cnt` saturates at 255. It is cleared only by `sys_rst_n`.
- Simultaneous events:
  - Lock loss takes priority over a stage release or a timeout expiry in the same cycle.
  - `lock_s` rising on the WAIT_LOCK timeout cycle goes to STABLE; no retry is counted.

## Timing
- Reset values:
  - `mmcm_rst`=1, `rst_n_out`=0, `ready`=0, `lock_lost`=0, `retry_cnt`=0.
  - State = RESET_MMCM, `cnt`=0.
- All outputs are registered; there are no combinational paths from input to output.
- From `sys_rst_n` deassertion, `mmcm_rst` stays high for exactly RST_CYCLES edges.
- Latency from `locked_in` to `lock_s` is 2 edges. The FSM reacts on the 3rd edge.
- With `locked_in` high from the cycle `mmcm_rst` falls and no glitches, `rst_n_out[0]` rises 2+1+STABLE_CYCLES edges later.
- `rst_n_out[k]` rises k·STAGE_GAP edges after `rst_n_out[0]`.
- `ready` rises 1 edge after the last stage is released.
- Resetting with `sys_rst_n` mid-sequence returns every output to its reset value immediately (asynchronously).

## Structure
- Package `clk_rst_pkg` holds:
  - the `seq_state_e` enum (5 states);
  - the `RETRY_W`=8 constant;
  - the `cnt_width()` function, which returns the counter width as `$clog2` of the largest of RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES and NUM_STAGES·STAGE_GAP.
- Sub-module `sync_2ff` implements the `locked_in` synchronizer: 1-bit, asynchronous active-low reset to 0.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGE_GAP=3, NUM_STAGES=3.

- **Clean lock.** `locked_in` rises 5 cycles after `mmcm_rst` falls. Required response:
  - `mmcm_rst` is high for 4 cycles;
  - `rst_n_out` goes 001→011→111 at 3-cycle spacing;
  - `ready`=1 one cycle later;
  - `retry_cnt`=0.
- **Timeout.** `locked_in` is held at 0. `mmcm_rst` re-pulses every 4+20 cycles and `retry_cnt` counts 1, 2, 3…
- **Glitch during STABLE.** Drop `locked_in` for 3 cycles at STABLE cycle 5. Required response:
  - `lock_lost` pulses once;
  - `retry_cnt`=1;
  - the FSM goes back to WAIT_LOCK with no `mmcm_rst` pulse;
  - a full 8-cycle STABLE window is then needed again.
- **Loss in RUN.** Drop `locked_in` while `ready`=1. Required response:
  - all `rst_n_out` are 0 and `ready`=0 exactly 3 edges later;
  - `mmcm_rst` is high for 4 cycles;
  - the sequence repeats.
- **Reset mid-RELEASE.** Assert `sys_rst_n`=0 when `rst_n_out`=011. All outputs return to their reset values immediately and `retry_cnt`=0.
- **Saturation.** Force 300 timeouts. `retry_cnt` holds at 255.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clock/reset sequencer.
//   seq_state_e : sequencer FSM states
//   RETRY_W     : width of the retry counter output
//   cnt_width() : width of the shared state counter, derived from the
//                 longest interval the FSM ever has to count
package clk_rst_pkg;

    typedef enum logic [2:0] {
        RESET_MMCM = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RELEASE    = 3'd3,
        RUN        = 3'd4
    } seq_state_e;

    localparam int RETRY_W = 8;

    // $clog2 of the largest count needed by any state. Every state counts
    // from 0 up to (interval - 1), so this many bits always suffice.
    function automatic int cnt_width(
        input int rst_cycles,
        input int lock_timeout,
        input int stable_cycles,
        input int num_stages,
        input int stage_gap
    );
        int largest;
        largest = rst_cycles;
        if (lock_timeout > largest)           largest = lock_timeout;
        if (stable_cycles > largest)          largest = stable_cycles;
        if (num_stages * stage_gap > largest) largest = num_stages * stage_gap;
        return $clog2(largest);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer for the clock wizard and its downstream logic.
// Holds the wizard in reset, waits for a stable lock, then releases the
// downstream resets one stage at a time. Loss of lock re-runs the sequence.
//   sys_clk   : free-running clock, the only clock in this block
//   sys_rst_n : asynchronous active-low reset
//   locked_in : wizard lock indication, asynchronous to sys_clk
//   mmcm_rst  : active-high reset to the wizard
//   rst_n_out : active-low staged resets, bit 0 released first
//   ready     : all stages released and lock held
//   lock_lost : one-cycle pulse on lock loss in STABLE/RELEASE/RUN
//   retry_cnt : saturating count of timeouts plus lock losses
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int NUM_STAGES    = 3,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  locked_in,
    output logic                  mmcm_rst,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [RETRY_W-1:0]    retry_cnt
);

    localparam int CW_RAW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                      NUM_STAGES, STAGE_GAP);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_STAGES - 1) * STAGE_GAP);

    logic lock_s;

    seq_state_e              state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    mmcm_rst_reg, mmcm_rst_next;
    logic [NUM_STAGES-1:0]   rst_n_reg, rst_n_next;
    logic                    ready_reg, ready_next;
    logic                    lock_lost_reg, lock_lost_next;
    logic [RETRY_W-1:0]      retry_reg, retry_next;
    logic                    retry_inc;

    sync_2ff u_lock_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (locked_in),
        .q     (lock_s)
    );

    // Next-state logic. Lock loss is tested before any count expiry so it
    // always wins over a timeout or a stage release in the same cycle.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + CW'(1);
        lock_lost_next = 1'b0;
        retry_inc      = 1'b0;

        case (state_reg)
            RESET_MMCM: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            WAIT_LOCK: begin
                // A lock arriving on the timeout cycle is taken, not retried.
                if (lock_s) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = RESET_MMCM;
                    cnt_next   = '0;
                    retry_inc  = 1'b1;
                end
            end
            STABLE: begin
                // A glitch here goes back to waiting without re-resetting
                // the wizard; the timeout window starts over.
                if (!lock_s) begin
                    state_next     = WAIT_LOCK;
                    cnt_next       = '0;
                    lock_lost_next = 1'b1;
                    retry_inc      = 1'b1;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_next     = RESET_MMCM;
                    cnt_next       = '0;
                    lock_lost_next = 1'b1;
                    retry_inc      = 1'b1;
                end else if (cnt_reg == RELEASE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                // Nothing to time in RUN; hold the counter at zero.
                cnt_next = cnt_reg;
                if (!lock_s) begin
                    state_next     = RESET_MMCM;
                    cnt_next       = '0;
                    lock_lost_next = 1'b1;
                    retry_inc      = 1'b1;
                end
            end
            default: begin
                state_next = RESET_MMCM;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that each registered output
    // changes on the same edge as the state it belongs to.
    always_comb begin
        mmcm_rst_next = (state_next == RESET_MMCM);
        ready_next    = (state_next == RUN);
        retry_next    = retry_reg;
        if (retry_inc && (retry_reg != {RETRY_W{1'b1}})) begin
            retry_next = retry_reg + RETRY_W'(1);
        end
    end

    // Stage k is released once the RELEASE counter reaches k*STAGE_GAP.
    // The counter only climbs inside RELEASE, so released stages stay high.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            logic reached;
            if (gi == 0) begin : g_first
                assign reached = 1'b1;
            end else begin : g_rest
                assign reached = (cnt_next >= CW'(gi * STAGE_GAP));
            end
            assign rst_n_next[gi] = (state_next == RUN) ||
                                    ((state_next == RELEASE) && reached);
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= RESET_MMCM;
            cnt_reg       <= '0;
            mmcm_rst_reg  <= 1'b1;
            rst_n_reg     <= '0;
            ready_reg     <= 1'b0;
            lock_lost_reg <= 1'b0;
            retry_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mmcm_rst_reg  <= mmcm_rst_next;
            rst_n_reg     <= rst_n_next;
            ready_reg     <= ready_next;
            lock_lost_reg <= lock_lost_next;
            retry_reg     <= retry_next;
        end
    end

    assign mmcm_rst  = mmcm_rst_reg;
    assign rst_n_out = rst_n_reg;
    assign ready     = ready_reg;
    assign lock_lost = lock_lost_reg;
    assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with small timing parameters.
module tb_clk_rst_seq;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       locked_in;
    logic       mmcm_rst;
    logic [2:0] rst_n_out;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_cnt;

    int n_cmp;
    int n_bad;

    clk_rst_seq #(
        .NUM_STAGES    (3),
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .STAGE_GAP     (3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .locked_in (locked_in),
        .mmcm_rst  (mmcm_rst),
        .rst_n_out (rst_n_out),
        .ready     (ready),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".mmcm_rst"},  32'(mmcm_rst),  32'd1);
        chk({tag, ".rst_n_out"}, 32'(rst_n_out), 32'd0);
        chk({tag, ".ready"},     32'(ready),     32'd0);
        chk({tag, ".lock_lost"}, 32'(lock_lost), 32'd0);
        chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'd0);
    endtask

    // Release sys_rst_n just after an edge; the next edge is edge 1.
    task automatic release_reset();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        sys_rst_n = 1'b0;
        locked_in = 1'b0;
        #23;
        chk_reset_vals("por");

        // Clean lock: edges counted from reset release.
        release_reset();
        tick_n(3);
        chk("clean.mmcm_hi_e3", 32'(mmcm_rst), 32'd1);
        tick();
        chk("clean.mmcm_lo_e4", 32'(mmcm_rst), 32'd0);
        // locked_in rises 5 cycles after mmcm_rst falls (relative edge 5).
        tick_n(5);
        locked_in = 1'b1;
        tick_n(10);
        chk("clean.rst_r15", 32'(rst_n_out), 32'd0);
        tick();
        chk("clean.rst_r16", 32'(rst_n_out), 32'd1);
        tick_n(2);
        chk("clean.rst_r18", 32'(rst_n_out), 32'd1);
        tick();
        chk("clean.rst_r19", 32'(rst_n_out), 32'd3);
        tick_n(3);
        chk("clean.rst_r22", 32'(rst_n_out), 32'd7);
        chk("clean.ready_r22", 32'(ready), 32'd0);
        tick();
        chk("clean.ready_r23", 32'(ready), 32'd1);
        chk("clean.retry", 32'(retry_cnt), 32'd0);
        chk("clean.mmcm", 32'(mmcm_rst), 32'd0);

        // Loss in RUN: outputs drop exactly 3 edges after locked_in falls.
        locked_in = 1'b0;
        tick_n(2);
        chk("loss.rst_l2", 32'(rst_n_out), 32'd7);
        chk("loss.ready_l2", 32'(ready), 32'd1);
        tick();
        chk("loss.rst_l3", 32'(rst_n_out), 32'd0);
        chk("loss.ready_l3", 32'(ready), 32'd0);
        chk("loss.mmcm_l3", 32'(mmcm_rst), 32'd1);
        chk("loss.pulse_l3", 32'(lock_lost), 32'd1);
        chk("loss.retry_l3", 32'(retry_cnt), 32'd1);
        tick();
        chk("loss.pulse_l4", 32'(lock_lost), 32'd0);
        tick_n(2);
        chk("loss.mmcm_l6", 32'(mmcm_rst), 32'd1);
        tick();
        chk("loss.mmcm_l7", 32'(mmcm_rst), 32'd0);
        locked_in = 1'b1;
        tick_n(10);
        chk("loss.rst_l17", 32'(rst_n_out), 32'd0);
        tick();
        chk("loss.rst_l18", 32'(rst_n_out), 32'd1);
        tick_n(3);
        chk("loss.rst_l21", 32'(rst_n_out), 32'd3);

        // Reset mid-RELEASE while rst_n_out == 011.
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals("midrel");

        // Glitch in STABLE at STABLE cycle 5.
        locked_in = 1'b0;
        release_reset();
        tick_n(3);
        chk("glitch.mmcm_e3", 32'(mmcm_rst), 32'd1);
        tick();
        chk("glitch.mmcm_e4", 32'(mmcm_rst), 32'd0);
        locked_in = 1'b1;
        tick_n(8);
        locked_in = 1'b0;
        tick_n(2);
        chk("glitch.pulse_e14", 32'(lock_lost), 32'd0);
        tick();
        chk("glitch.pulse_e15", 32'(lock_lost), 32'd1);
        chk("glitch.retry_e15", 32'(retry_cnt), 32'd1);
        chk("glitch.mmcm_e15", 32'(mmcm_rst), 32'd0);
        locked_in = 1'b1;
        tick();
        chk("glitch.pulse_e16", 32'(lock_lost), 32'd0);
        for (int e = 17; e <= 25; e++) begin
            tick();
            chk($sformatf("glitch.mmcm_e%0d", e), 32'(mmcm_rst), 32'd0);
            chk($sformatf("glitch.rst_e%0d", e), 32'(rst_n_out), 32'd0);
        end
        tick();
        chk("glitch.rst_e26", 32'(rst_n_out), 32'd1);
        chk("glitch.retry_e26", 32'(retry_cnt), 32'd1);

        // lock_s rises on the timeout cycle: goes to STABLE, no retry.
        sys_rst_n = 1'b0;
        locked_in = 1'b0;
        release_reset();
        tick_n(21);
        locked_in = 1'b1;
        tick_n(2);
        chk("edge.mmcm_t23", 32'(mmcm_rst), 32'd0);
        tick();
        chk("edge.mmcm_t24", 32'(mmcm_rst), 32'd0);
        chk("edge.retry_t24", 32'(retry_cnt), 32'd0);
        tick_n(7);
        chk("edge.rst_t31", 32'(rst_n_out), 32'd0);
        tick();
        chk("edge.rst_t32", 32'(rst_n_out), 32'd1);

        // Timeouts with locked_in held low; period is 4 + 20 edges.
        sys_rst_n = 1'b0;
        locked_in = 1'b0;
        release_reset();
        tick_n(23);
        chk("tmo.mmcm_t23", 32'(mmcm_rst), 32'd0);
        chk("tmo.retry_t23", 32'(retry_cnt), 32'd0);
        tick();
        chk("tmo.mmcm_t24", 32'(mmcm_rst), 32'd1);
        chk("tmo.retry_t24", 32'(retry_cnt), 32'd1);
        chk("tmo.pulse_t24", 32'(lock_lost), 32'd0);
        tick_n(3);
        chk("tmo.mmcm_t27", 32'(mmcm_rst), 32'd1);
        tick();
        chk("tmo.mmcm_t28", 32'(mmcm_rst), 32'd0);
        tick_n(20);
        chk("tmo.mmcm_t48", 32'(mmcm_rst), 32'd1);
        chk("tmo.retry_t48", 32'(retry_cnt), 32'd2);
        tick_n(24);
        chk("tmo.retry_t72", 32'(retry_cnt), 32'd3);

        // Saturation after 300 timeouts.
        tick_n(24 * 254 - 72);
        chk("sat.retry_254", 32'(retry_cnt), 32'd254);
        tick_n(24);
        chk("sat.retry_255", 32'(retry_cnt), 32'd255);
        tick_n(24 * 45);
        chk("sat.retry_300", 32'(retry_cnt), 32'd255);
        chk("sat.mmcm_300", 32'(mmcm_rst), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
